// File: rtl/exe_div_ctrl.sv
// Sequencer between the EXE stage and a fixed-latency AXI-stream divider pair.
// Holds one div/mod op at a time, selects quotient or remainder and supports flush.
module exe_div_ctrl #(
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 8,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_rem,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  input  logic        cancel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        ip_sel_signed,
  output logic        ip_tvalid,
  input  logic        ip_tready,
  output logic [31:0] ip_dividend,
  output logic [31:0] ip_divisor,
  input  logic        ip_dout_valid,
  input  logic [63:0] ip_dout,
  output logic        err_timeout
);

  // State bits double as the registered handshake outputs: {req_ready, ip_tvalid, resp_valid}.
  typedef enum logic [2:0] {
    IDLE  = 3'b100,
    ISSUE = 3'b010,
    WAIT  = 3'b000,
    DONE  = 3'b001
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             rem_q;
  logic             kill;
  logic [CNT_W-1:0] cnt;

  assign req_ready  = state[2];
  assign ip_tvalid  = state[1];
  assign resp_valid = state[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      kill          <= 1'b0;
      cnt           <= '0;
      err_timeout   <= 1'b0;
      rem_q         <= 1'b0;
      ip_sel_signed <= 1'b0;
      ip_dividend   <= '0;
      ip_divisor    <= '0;
      resp_result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !cancel) begin
            ip_sel_signed <= req_signed;
            rem_q         <= req_rem;
            ip_dividend   <= req_dividend;
            ip_divisor    <= req_divisor;
            kill          <= 1'b0;
            if (ZERO_BYPASS && req_divisor == '0) begin
              resp_result <= req_rem ? req_dividend : '1;
              state       <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // A flushed op is still issued so its output can be drained and dropped.
          if (cancel) kill <= 1'b1;
          if (ip_tready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          // Flag rises on the same edge that cnt reaches TIMEOUT.
          if (cnt >= TO_M1) err_timeout <= 1'b1;
          if (ip_dout_valid) begin
            if (kill || cancel) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              resp_result <= rem_q ? ip_dout[31:0] : ip_dout[63:32];
              state       <= DONE;
            end
          end else if (cancel) begin
            kill <= 1'b1;
          end
        end
        DONE: begin
          if (cancel || resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Randomized bench for exe_div_ctrl: an arithmetic divider model drives the IP side,
// expected results come from plain signed/unsigned division.
module tb_exe_div_ctrl;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 0, req_signed = 0, req_rem = 0, cancel = 0, resp_ready = 0;
  logic [31:0] req_dividend = '0, req_divisor = '0;
  logic        ip_tready = 0, ip_dout_valid = 0;
  logic [63:0] ip_dout = '0;
  logic        req_ready, resp_valid, ip_sel_signed, ip_tvalid, err_timeout;
  logic [31:0] resp_result, ip_dividend, ip_divisor;

  int          n_chk = 0, n_fail = 0;
  int          ip_lat = 1, ip_cnt = 0;
  bit          ip_mute = 0;
  logic [63:0] ip_q = '0;
  logic [31:0] last_res;

  exe_div_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed), .req_rem(req_rem),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .cancel(cancel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .ip_sel_signed(ip_sel_signed), .ip_tvalid(ip_tvalid), .ip_tready(ip_tready),
    .ip_dividend(ip_dividend), .ip_divisor(ip_divisor),
    .ip_dout_valid(ip_dout_valid), .ip_dout(ip_dout), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // One clock; the divider model captures the pre-edge handshake and answers ip_lat cycles later.
  task automatic tick();
    bit          hs;
    logic [63:0] d;
    hs = ip_tvalid && ip_tready;
    d  = '0;
    if (hs) d = ref_div(ip_sel_signed, ip_dividend, ip_divisor);
    @(posedge clk); #1;
    ip_dout_valid = 0;
    ip_dout = {$urandom, $urandom};
    if (ip_cnt > 0) begin
      ip_cnt--;
      if (ip_cnt == 0 && !ip_mute) begin
        ip_dout_valid = 1;
        ip_dout = ip_q;
      end
    end
    if (hs) begin
      ip_cnt = ip_lat;
      ip_q   = d;
    end
  endtask

  task automatic run_op(input bit sg, input bit rm, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int trw, input int rrw);
    logic [63:0] d;
    logic [31:0] exp;
    int          n;
    d   = (b == '0) ? 64'h0 : ref_div(sg, a, b);
    exp = (b == '0) ? (rm ? a : 32'hFFFF_FFFF) : (rm ? d[31:0] : d[63:32]);
    ip_lat = lat;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_signed = sg; req_rem = rm; req_dividend = a; req_divisor = b;
    tick();
    req_valid = 0; req_dividend = $urandom; req_divisor = $urandom; req_signed = $urandom; req_rem = $urandom;
    chk("req_ready_busy", req_ready, 0);
    if (b != '0) begin
      chk("resp_early", resp_valid, 0);
      for (int i = 0; i <= trw; i++) begin
        chk("tvalid_hold", ip_tvalid, 1);
        chk("opnd_hold", {ip_dividend, ip_divisor}, {a, b});
        chk("sel_signed", ip_sel_signed, sg);
        if (i < trw) tick();
      end
      ip_tready = 1;
      tick();
      ip_tready = 0;
      chk("tvalid_drop", ip_tvalid, 0);
      n = 0;
      while (!resp_valid && n < 200) begin
        tick();
        n++;
      end
      chk("latency", n, lat + 1);
    end else begin
      chk("bypass_tvalid", ip_tvalid, 0);
    end
    chk("resp_valid", resp_valid, 1);
    chk("result", resp_result, exp);
    last_res = resp_result;
    for (int i = 0; i < rrw; i++) begin
      tick();
      chk("resp_hold", resp_valid, 1);
      chk("result_hold", resp_result, exp);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  initial begin
    int          n;
    bit          seen, bad, rdy_before;
    logic [31:0] a, b;

    #2 resetn = 0;
    #5;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {resp_valid, ip_tvalid, ip_sel_signed, err_timeout}, 0);
    chk("rst_regs", {resp_result, ip_dividend, ip_divisor}, 0);
    @(posedge clk); #1;
    resetn = 1;

    // Stray dout in IDLE is ignored.
    ip_dout_valid = 1; ip_dout = 64'h1234_5678_9abc_def0;
    tick();
    chk("stray_dout", {resp_valid, req_ready}, 2'b01);

    run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 8, 0, 3);
    chk("t1_value", last_res, 32'hFFFF_FFFD);
    run_op(0, 1, 32'hFFFF_FFFF, 32'd10, 5, 0, 0);
    chk("t2_value", last_res, 32'd5);
    run_op(1, 0, 32'd123, 32'd0, 1, 0, 0);
    chk("t3_quot", last_res, 32'hFFFF_FFFF);
    run_op(0, 1, 32'd123, 32'd0, 1, 0, 1);
    chk("t3_rem", last_res, 32'd123);
    run_op(1, 1, 32'hFFFF_FF9C, 32'd7, 3, 4, 0);

    // Cancel in IDLE blocks acceptance.
    req_valid = 1; cancel = 1; req_dividend = 50; req_divisor = 5;
    tick();
    req_valid = 0; cancel = 0;
    chk("cancel_idle", {req_ready, ip_tvalid, resp_valid}, 3'b100);

    // Cancel in DONE drops the response even with resp_ready.
    req_valid = 1; req_rem = 1; req_dividend = 77; req_divisor = 0;
    tick();
    req_valid = 0;
    chk("done_before_cancel", resp_valid, 1);
    cancel = 1; resp_ready = 1;
    tick();
    cancel = 0; resp_ready = 0;
    chk("cancel_done", {resp_valid, req_ready}, 2'b01);

    // Cancel two cycles after issue: IP output drained, no response.
    ip_lat = 6;
    req_valid = 1; req_signed = 1; req_rem = 0; req_dividend = 100; req_divisor = 7;
    tick();
    req_valid = 0;
    ip_tready = 1;
    tick();
    ip_tready = 0;
    tick(); tick();
    cancel = 1;
    tick();
    cancel = 0;
    n = 0; seen = 0; bad = 0; rdy_before = 1;
    while (n < 50 && !seen) begin
      seen = ip_dout_valid;
      rdy_before = req_ready;
      tick();
      n++;
      if (resp_valid) bad = 1;
    end
    chk("cancel_dout_seen", seen, 1);
    chk("cancel_no_resp", bad, 0);
    chk("cancel_rdy_before", rdy_before, 0);
    chk("cancel_rdy_after", req_ready, 1);
    run_op(1, 1, 32'd100, 32'd7, 4, 1, 0);
    chk("after_cancel", last_res, 32'd2);

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      case ($urandom % 8)
        0:       b = 0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom % 3 == 0) a = $urandom_range(0, 1000);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
      run_op($urandom % 2, $urandom % 2, a, b, $urandom_range(1, 12), $urandom_range(0, 3),
             $urandom_range(0, 3));
    end

    // Timeout: IP never answers.
    ip_mute = 1; ip_lat = 1;
    req_valid = 1; req_signed = 0; req_rem = 0; req_dividend = 9; req_divisor = 3;
    tick();
    req_valid = 0;
    ip_tready = 1;
    tick();
    ip_tready = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("err_pre", err_timeout, 0);
    tick();
    chk("err_rise", err_timeout, 1);
    repeat (5) tick();
    chk("err_sticky", {err_timeout, req_ready, resp_valid}, 3'b100);
    #2 resetn = 0;
    #1;
    chk("rst_mid_wait", {err_timeout, req_ready, resp_valid, ip_tvalid}, 4'b0100);
    @(posedge clk); #1;
    resetn = 1; ip_mute = 0; ip_cnt = 0; ip_dout_valid = 0;
    run_op(0, 0, 32'd1000, 32'd7, 2, 0, 0);
    chk("after_reset", last_res, 32'd142);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
